// File: rtl/crc_pkg.sv
// rtl/crc_pkg.sv - shared types and width-agnostic CRC helpers for crc_generic
package crc_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } t_crc_state;

    // Bit-reverse the low 'width' bits of v; bits above 'width' return zero.
    function automatic logic [63:0] f_reflect(input logic [63:0] v, input int width);
        logic [63:0] r;
        logic [5:0]  idx;
        r = '0;
        for (int i = 0; i < 64; i++) begin
            if (i < width) begin
                idx  = 6'(width - 1 - i);
                r[i] = v[idx];
            end
        end
        return r;
    endfunction

    // Serial LFSR over data_width bits, MSB first unless reflect_in; one bit per iteration.
    function automatic logic [31:0] f_crc_step(
        input logic [31:0] crc,
        input logic [63:0] data,
        input logic [31:0] poly,
        input int          crc_width,
        input int          data_width,
        input logic        reflect_in
    );
        logic [31:0] c;
        logic [31:0] mask;
        logic [4:0]  top;
        logic [5:0]  idx;
        logic        fb;
        mask = (crc_width >= 32) ? 32'hFFFF_FFFF : ((32'd1 << crc_width) - 32'd1);
        top  = 5'(crc_width - 1);
        c    = crc & mask;
        for (int k = 0; k < 64; k++) begin
            if (k < data_width) begin
                idx = reflect_in ? 6'(k) : 6'(data_width - 1 - k);
                fb  = c[top] ^ data[idx];
                c   = (c << 1) & mask;
                if (fb) begin
                    c = c ^ (poly & mask);
                end
            end
        end
        return c;
    endfunction

endpackage

// File: rtl/crc_generic_if.sv
// rtl/crc_generic_if.sv - beat/frame stream and result bundle for crc_generic
interface crc_generic_if #(
    parameter int CRC_W  = 16,
    parameter int DATA_W = 8
);
    logic              i_val;
    logic              i_sof;
    logic              i_eof;
    logic [DATA_W-1:0] i_data;
    logic [CRC_W-1:0]  i_crc_exp;
    logic [CRC_W-1:0]  o_crc;
    logic              o_crc_val;
    logic              o_crc_ok;
    logic              o_busy;
    logic              o_frame_err;

    modport master (
        output i_val, i_sof, i_eof, i_data, i_crc_exp,
        input  o_crc, o_crc_val, o_crc_ok, o_busy, o_frame_err
    );

    modport slave (
        input  i_val, i_sof, i_eof, i_data, i_crc_exp,
        output o_crc, o_crc_val, o_crc_ok, o_busy, o_frame_err
    );
endinterface

// File: rtl/crc_step_comb.sv
// rtl/crc_step_comb.sv - single-cycle combinational CRC step for one data beat
module crc_step_comb
    import crc_pkg::*;
#(
    parameter int                     G_CRC_WIDTH  = 16,
    parameter int                     G_DATA_WIDTH = 8,
    parameter logic [G_CRC_WIDTH-1:0] G_POLY       = 16'h1021,
    parameter bit                     G_REFLECT_IN = 1'b0
) (
    input  logic [G_CRC_WIDTH-1:0]  crc_in,
    input  logic [G_DATA_WIDTH-1:0] data,
    output logic [G_CRC_WIDTH-1:0]  crc_out
);

    always_comb begin
        crc_out = G_CRC_WIDTH'(f_crc_step(32'(crc_in), 64'(data), 32'(G_POLY),
                                          G_CRC_WIDTH, G_DATA_WIDTH, G_REFLECT_IN));
    end

endmodule

// File: rtl/crc_generic.sv
// rtl/crc_generic.sv - frame-oriented parametrised CRC engine with compare and framing checks
module crc_generic
    import crc_pkg::*;
#(
    parameter int                     G_CRC_WIDTH   = 16,
    parameter int                     G_DATA_WIDTH  = 8,
    parameter logic [G_CRC_WIDTH-1:0] G_POLY        = 16'h1021,
    parameter logic [G_CRC_WIDTH-1:0] G_CRC_INIT    = 16'hFFFF,
    parameter logic [G_CRC_WIDTH-1:0] G_XOR_OUT     = 16'h0000,
    parameter bit                     G_REFLECT_IN  = 1'b0,
    parameter bit                     G_REFLECT_OUT = 1'b0
) (
    input  logic          clk,
    input  logic          rst,
    crc_generic_if.slave  bus
);

    t_crc_state             state;
    logic [G_CRC_WIDTH-1:0] crc_reg;
    logic [G_CRC_WIDTH-1:0] base;
    logic [G_CRC_WIDTH-1:0] step_out;
    logic [G_CRC_WIDTH-1:0] final_crc;

    // An SOF beat always restarts from INIT, even when it aborts a running frame.
    assign base = bus.i_sof ? G_CRC_INIT : crc_reg;

    crc_step_comb #(
        .G_CRC_WIDTH  (G_CRC_WIDTH),
        .G_DATA_WIDTH (G_DATA_WIDTH),
        .G_POLY       (G_POLY),
        .G_REFLECT_IN (G_REFLECT_IN)
    ) u_step (
        .crc_in  (base),
        .data    (bus.i_data),
        .crc_out (step_out)
    );

    always_comb begin
        if (G_REFLECT_OUT) begin
            final_crc = G_CRC_WIDTH'(f_reflect(64'(step_out), G_CRC_WIDTH)) ^ G_XOR_OUT;
        end else begin
            final_crc = step_out ^ G_XOR_OUT;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state           <= IDLE;
            crc_reg         <= G_CRC_INIT;
            bus.o_crc       <= '0;
            bus.o_crc_ok    <= 1'b0;
            bus.o_crc_val   <= 1'b0;
            bus.o_busy      <= 1'b0;
            bus.o_frame_err <= 1'b0;
        end else begin
            bus.o_crc_val   <= 1'b0;
            bus.o_frame_err <= 1'b0;
            if (bus.i_val) begin
                case (state)
                    IDLE: begin
                        if (bus.i_sof) begin
                            if (bus.i_eof) begin
                                crc_reg       <= G_CRC_INIT;
                                bus.o_crc     <= final_crc;
                                bus.o_crc_ok  <= (final_crc == bus.i_crc_exp);
                                bus.o_crc_val <= 1'b1;
                            end else begin
                                crc_reg    <= step_out;
                                state      <= RUN;
                                bus.o_busy <= 1'b1;
                            end
                        end else begin
                            bus.o_frame_err <= 1'b1;
                        end
                    end
                    RUN: begin
                        // SOF inside a frame drops the old frame silently apart from the error strobe.
                        if (bus.i_sof) begin
                            bus.o_frame_err <= 1'b1;
                        end
                        if (bus.i_eof) begin
                            crc_reg       <= G_CRC_INIT;
                            bus.o_crc     <= final_crc;
                            bus.o_crc_ok  <= (final_crc == bus.i_crc_exp);
                            bus.o_crc_val <= 1'b1;
                            state         <= IDLE;
                            bus.o_busy    <= 1'b0;
                        end else begin
                            crc_reg <= step_out;
                        end
                    end
                    default: begin
                        state      <= IDLE;
                        bus.o_busy <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_crc_generic.sv
// tb/tb_crc_generic.sv - scoreboard bench for crc_generic, CCITT-FALSE and CRC-32 instances in parallel
module tb_crc_generic;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    crc_generic_if #(.CRC_W(16), .DATA_W(8)) b16 ();
    crc_generic_if #(.CRC_W(32), .DATA_W(8)) b32 ();

    crc_generic dut16 (
        .clk (clk),
        .rst (rst),
        .bus (b16)
    );

    crc_generic #(
        .G_CRC_WIDTH   (32),
        .G_DATA_WIDTH  (8),
        .G_POLY        (32'h04C11DB7),
        .G_CRC_INIT    (32'hFFFFFFFF),
        .G_XOR_OUT     (32'hFFFFFFFF),
        .G_REFLECT_IN  (1'b1),
        .G_REFLECT_OUT (1'b1)
    ) dut32 (
        .clk (clk),
        .rst (rst),
        .bus (b32)
    );

    typedef struct {
        logic [31:0] crc;
        logic        ok;
    } exp_t;

    exp_t       q16[$];
    exp_t       q32[$];
    logic [7:0] frame[$];
    int         checks = 0;
    int         failures = 0;
    int         exp_ferr = 0;
    int         obs_ferr16 = 0;
    int         obs_ferr32 = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Textbook byte-at-a-time CRC: shift each byte into the top of the register, then 8 polynomial divisions.
    function automatic logic [31:0] ref_crc(input int w, input logic [31:0] poly, input logic [31:0] init,
                                            input logic [31:0] xorout, input bit refin, input bit refout);
        longint unsigned r, mask, top, t;
        logic [7:0] b;
        mask = (64'd1 << w) - 64'd1;
        top  = 64'd1 << (w - 1);
        r    = 64'(init);
        foreach (frame[i]) begin
            b = frame[i];
            if (refin) b = {<<{b}};
            r = r ^ (64'(b) << (w - 8));
            for (int k = 0; k < 8; k++) begin
                if ((r & top) != 0) r = ((r << 1) ^ 64'(poly)) & mask;
                else                r = (r << 1) & mask;
            end
        end
        if (refout) begin
            t = 0;
            for (int i = 0; i < w; i++) if (r[i]) t[w-1-i] = 1'b1;
            r = t;
        end
        return 32'(r) ^ xorout;
    endfunction

    task automatic drive(input logic v, input logic s, input logic e, input logic [7:0] d,
                         input logic [15:0] e16, input logic [31:0] e32);
        b16.i_val = v; b16.i_sof = s; b16.i_eof = e; b16.i_data = d; b16.i_crc_exp = e16;
        b32.i_val = v; b32.i_sof = s; b32.i_eof = e; b32.i_data = d; b32.i_crc_exp = e32;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 1'b0, 8'h00, 16'h0, 32'h0);
    endtask

    task automatic load_digits(input int n);
        frame.delete();
        for (int i = 0; i < n; i++) frame.push_back(8'h31 + 8'(i));
    endtask

    task automatic send_frame(input bit bad, input int gaps, input bit use_k,
                              input logic [15:0] k16, input logic [31:0] k32);
        logic [15:0] r16, x16;
        logic [31:0] r32, x32;
        r16 = use_k ? k16 : 16'(ref_crc(16, 32'h1021, 32'hFFFF, 32'h0, 1'b0, 1'b0));
        r32 = use_k ? k32 : ref_crc(32, 32'h04C11DB7, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 1'b1);
        x16 = bad ? (r16 ^ 16'($urandom_range(1, 65535))) : r16;
        x32 = bad ? (r32 ^ ($urandom | 32'h1)) : r32;
        for (int i = 0; i < frame.size(); i++) begin
            if (i > 0 && gaps > 0) idle($urandom_range(0, gaps));
            if (i == frame.size() - 1) begin
                q16.push_back('{32'(r16), !bad});
                q32.push_back('{r32, !bad});
            end
            drive(1'b1, i == 0, i == frame.size() - 1, frame[i], x16, x32);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (!rst) begin
            if (b16.o_frame_err) obs_ferr16++;
            if (b32.o_frame_err) obs_ferr32++;
            if (b16.o_crc_val) begin
                if (q16.size() == 0) begin
                    checks++; failures++;
                    $display("FAIL crc16_strobe: got unexpected strobe crc=%0h expected none", b16.o_crc);
                end else begin
                    e = q16.pop_front();
                    check("crc16", 32'(b16.o_crc), e.crc);
                    check("crc16_ok", 32'(b16.o_crc_ok), 32'(e.ok));
                end
            end
            if (b32.o_crc_val) begin
                if (q32.size() == 0) begin
                    checks++; failures++;
                    $display("FAIL crc32_strobe: got unexpected strobe crc=%0h expected none", b32.o_crc);
                end else begin
                    e = q32.pop_front();
                    check("crc32", b32.o_crc, e.crc);
                    check("crc32_ok", 32'(b32.o_crc_ok), 32'(e.ok));
                end
            end
        end
    end

    initial begin
        rst = 1'b1;
        b16.i_val = 0; b16.i_sof = 0; b16.i_eof = 0; b16.i_data = 0; b16.i_crc_exp = 0;
        b32.i_val = 0; b32.i_sof = 0; b32.i_eof = 0; b32.i_data = 0; b32.i_crc_exp = 0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_crc16", 32'(b16.o_crc), 32'h0);
        check("rst_val16", 32'(b16.o_crc_val), 32'h0);
        check("rst_ok16", 32'(b16.o_crc_ok), 32'h0);
        check("rst_busy16", 32'(b16.o_busy), 32'h0);
        check("rst_ferr16", 32'(b16.o_frame_err), 32'h0);
        check("rst_crc32", b32.o_crc, 32'h0);
        check("rst_busy32", 32'(b32.o_busy), 32'h0);
        rst = 1'b0;

        load_digits(9);
        send_frame(1'b0, 0, 1'b1, 16'h29B1, 32'hCBF43926);
        idle(2);

        load_digits(9);
        send_frame(1'b1, 0, 1'b1, 16'h29B1, 32'hCBF43926);
        send_frame(1'b0, 0, 1'b1, 16'h29B1, 32'hCBF43926);
        idle(1);

        frame.delete();
        frame.push_back(8'h00);
        send_frame(1'b0, 0, 1'b1, 16'hE1F0, 32'hD202EF8D);
        idle(1);

        exp_ferr += 2;
        drive(1'b1, 1'b0, 1'b0, 8'h55, 16'h0, 32'h0);
        drive(1'b1, 1'b0, 1'b1, 8'hAA, 16'h0, 32'h0);
        idle(2);

        load_digits(4);
        for (int i = 0; i < 4; i++) drive(1'b1, i == 0, 1'b0, frame[i], 16'h0, 32'h0);
        check("busy16_run", 32'(b16.o_busy), 32'h1);
        exp_ferr++;
        load_digits(9);
        send_frame(1'b0, 0, 1'b1, 16'h29B1, 32'hCBF43926);
        #4;
        check("busy16_done", 32'(b16.o_busy), 32'h0);
        idle(1);

        load_digits(9);
        for (int i = 0; i < 4; i++) drive(1'b1, i == 0, 1'b0, frame[i], 16'h0, 32'h0);
        rst = 1'b1;
        drive(1'b1, 1'b0, 1'b0, frame[4], 16'h0, 32'h0);
        rst = 1'b0;
        check("midrst_crc16", 32'(b16.o_crc), 32'h0);
        check("midrst_val16", 32'(b16.o_crc_val), 32'h0);
        check("midrst_ok16", 32'(b16.o_crc_ok), 32'h0);
        check("midrst_busy16", 32'(b16.o_busy), 32'h0);
        check("midrst_crc32", b32.o_crc, 32'h0);
        idle(1);
        send_frame(1'b0, 0, 1'b1, 16'h29B1, 32'hCBF43926);
        idle(1);

        for (int f = 0; f < 40; f++) begin
            frame.delete();
            for (int i = 0; i < $urandom_range(1, 12); i++) frame.push_back(8'($urandom));
            send_frame($urandom_range(0, 3) == 0, 2, 1'b0, 16'h0, 32'h0);
            idle($urandom_range(0, 2));
        end

        idle(5);
        check("q16_drained", 32'(q16.size()), 32'h0);
        check("q32_drained", 32'(q32.size()), 32'h0);
        check("ferr16_count", 32'(obs_ferr16), 32'(exp_ferr));
        check("ferr32_count", 32'(obs_ferr32), 32'(exp_ferr));
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
